parity_engine_arbiter: RTL and testbench



---
 rtl/parity_engine_arbiter.sv | 124 ++++++++++++
 tb/tb_parity_engine_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_engine_arbiter.sv
// Round-robin arbiter that time-shares one serial parity engine among N_REQ requesters.
// A granted word is shifted out LSB first; done pulses in the cycle after grant edge + WIDTH.
module parity_engine_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   parity_out,
    output logic                   busy,
    output logic                   ser_x
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [PW:0]   N_WIDE   = (PW + 1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     pick;
    logic [PW:0]       idx;
    logic              found;
    logic [WIDTH-1:0]  sr;
    logic [CW-1:0]     cnt;
    logic              acc;

    // Scan from the pointer upward, wrapping explicitly so non-power-of-2 N_REQ works.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (PW + 1)'(i);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= '0;
            done       <= '0;
            parity_out <= 1'b0;
            ptr        <= '0;
            sel        <= '0;
            sr         <= '0;
            cnt        <= '0;
            acc        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt <= N_REQ'(1) << pick;
                        sel <= pick;
                        sr  <= data[pick*WIDTH +: WIDTH];
                        acc <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc ^ sr[0];
                    sr  <= sr >> 1;
                    cnt <= cnt + CW'(1);
                    // Fold in the last bit here so the result is ready with done.
                    if (cnt == LAST_BIT) begin
                        done       <= gnt;
                        parity_out <= acc ^ sr[0] ^ PARITY_ODD;
                    end
                end
                DONE: begin
                    gnt  <= '0;
                    done <= '0;
                    ptr  <= (sel == LAST_IDX) ? '0 : sel + PW'(1);
                end
                default: begin
                    gnt  <= '0;
                    done <= '0;
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign ser_x = (state == SHIFT) & sr[0];

endmodule

// File: tb/tb_parity_engine_arbiter.sv
// Bench for parity_engine_arbiter: vector table plus hand-written arbitration sequences,
// with a scoreboard of expected {requester, parity} results checked on every done pulse.
module tb_parity_engine_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt, done, gnt_o, done_o;
    logic           parity_out, busy, ser_x;
    logic           par_o, busy_o, ser_o;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] word;
        logic       par;
    } vec_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       par;
    } exp_t;

    vec_t tbl [10];
    exp_t sbq [$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    parity_engine_arbiter #(.N_REQ(N), .WIDTH(W), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt), .done(done), .parity_out(parity_out),
        .busy(busy), .ser_x(ser_x)
    );

    parity_engine_arbiter #(.N_REQ(N), .WIDTH(W), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt_o), .done(done_o), .parity_out(par_o),
        .busy(busy_o), .ser_x(ser_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done", 32'(done), 32'(4'b1 << e.idx));
                chk("parity", 32'(parity_out), 32'(e.par));
                chk("done_odd", 32'(done_o), 32'(4'b1 << e.idx));
                chk("parity_odd", 32'(par_o), 32'(!e.par));
            end
        end
    end

    task automatic wait_gnt(input string nm);
        int k = 0;
        while (gnt == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (gnt == '0) chk({nm, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (done == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (done == '0) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (gnt != '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (gnt != '0) chk({nm, "_idle_timeout"}, 0, 1);
    endtask

    task automatic reset_dut();
        req   = '0;
        data  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        int         order [5];
        int         last;

        tbl[0] = '{2'd0, 8'h07, 1'b1};
        tbl[1] = '{2'd0, 8'hFF, 1'b0};
        tbl[2] = '{2'd0, 8'h00, 1'b0};
        tbl[3] = '{2'd0, 8'h80, 1'b1};
        tbl[4] = '{2'd1, 8'h03, 1'b0};
        tbl[5] = '{2'd2, 8'h01, 1'b1};
        tbl[6] = '{2'd3, 8'hA5, 1'b0};
        tbl[7] = '{2'd1, 8'hFE, 1'b1};
        tbl[8] = '{2'd2, 8'h55, 1'b0};
        tbl[9] = '{2'd3, 8'hE0, 1'b1};

        req   = '0;
        data  = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_parity", 32'(parity_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ser_x", 32'(ser_x), 0);
        chk("rst_busy_odd", 32'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single word, bit stream visible on ser_x
        @(negedge clk);
        w         = 8'h07;
        data[7:0] = w;
        req       = 4'b0001;
        sbq.push_back('{2'd0, 1'b1});
        for (int b = 0; b < W; b++) begin
            @(negedge clk);
            if (b == 0) chk("t1_gnt", 32'(gnt), 32'h1);
            chk("t1_ser_x", 32'(ser_x), 32'(w[b]));
            chk("t1_busy", 32'(busy), 1);
        end
        wait_done("t1");
        req = '0;
        @(negedge clk);
        chk("t1_done_once", 32'(done), 0);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_ser_idle", 32'(ser_o | ser_x), 0);
        chk("t1_parity_held", 32'(parity_out), 1);

        for (int i = 0; i < 10; i++) begin
            data[tbl[i].idx*W +: W] = tbl[i].word;
            req = 4'b1 << tbl[i].idx;
            sbq.push_back('{tbl[i].idx, tbl[i].par});
            wait_gnt("tbl");
            chk("tbl_gnt", 32'(gnt), 32'(4'b1 << tbl[i].idx));
            wait_done("tbl");
            req = '0;
            @(negedge clk);
            chk("tbl_idle_gnt", 32'(gnt), 0);
            chk("tbl_parity_held", 32'(parity_out), 32'(tbl[i].par));
        end

        // all four requesting: rotation and grant spacing
        reset_dut();
        data  = {8'h0F, 8'h07, 8'h03, 8'h01};
        req   = 4'hF;
        order = '{0, 1, 2, 3, 0};
        sbq.push_back('{2'd0, 1'b1});
        sbq.push_back('{2'd1, 1'b0});
        sbq.push_back('{2'd2, 1'b1});
        sbq.push_back('{2'd3, 1'b0});
        sbq.push_back('{2'd0, 1'b1});
        last = 0;
        for (int t = 0; t < 5; t++) begin
            wait_gnt("rr");
            chk("rr_gnt", 32'(gnt), 32'(4'b1 << order[t]));
            if (t > 0) chk("rr_spacing", 32'(cyc - last), 10);
            last = cyc;
            if (t == 4) req = '0;
            wait_idle("rr");
        end

        // req0 held, req2 joins during SHIFT
        reset_dut();
        data[7:0]   = 8'h03;
        data[23:16] = 8'h01;
        req         = 4'b0001;
        order       = '{0, 2, 0, 2, 0};
        sbq.push_back('{2'd0, 1'b0});
        sbq.push_back('{2'd2, 1'b1});
        sbq.push_back('{2'd0, 1'b0});
        sbq.push_back('{2'd2, 1'b1});
        for (int t = 0; t < 4; t++) begin
            wait_gnt("alt");
            chk("alt_gnt", 32'(gnt), 32'(4'b1 << order[t]));
            if (t == 0) begin
                repeat (2) @(negedge clk);
                req = 4'b0101;
            end
            if (t == 3) req = '0;
            wait_idle("alt");
        end

        // req dropped and data changed mid-transaction
        reset_dut();
        data[15:8] = 8'h01;
        req        = 4'b0010;
        sbq.push_back('{2'd1, 1'b1});
        wait_gnt("drop");
        chk("drop_gnt", 32'(gnt), 32'h2);
        repeat (3) @(negedge clk);
        req        = '0;
        data[15:8] = 8'h03;
        wait_done("drop");
        @(negedge clk);
        chk("drop_idle_gnt", 32'(gnt), 0);
        chk("drop_idle_busy", 32'(busy), 0);

        // asynchronous reset mid-SHIFT, parity_out currently 1
        data[7:0] = 8'hFF;
        req       = 4'b0001;
        wait_gnt("arst");
        repeat (3) @(negedge clk);
        chk("arst_pre_ser_x", 32'(ser_x), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ser_x", 32'(ser_x), 0);
        chk("arst_parity", 32'(parity_out), 0);
        chk("arst_parity_odd", 32'(par_o), 0);
        req  = 4'hF;
        data = {8'h11, 8'h22, 8'h33, 8'h07};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back('{2'd0, 1'b1});
        wait_gnt("arst_rel");
        chk("arst_rel_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_done("arst_rel");
        wait_idle("arst_rel");
        repeat (2) @(negedge clk);

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
